// File: rtl/fifo_pkg.sv
// Shared pointer types and Gray/binary helpers for the async FIFO.
// Helpers work on a wide word; callers zero-extend and truncate.
package fifo_pkg;

  localparam int PTR_MAX        = 32;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef logic [ADDR_WIDTH_DEF:0] ptr_t;
  typedef logic [PTR_MAX-1:0]      pword_t;

  function automatic pword_t bin2gray(
    input pword_t b
  );
    return b ^ (b >> 1);
  endfunction

  // Zero bits above the real width leave the prefix XOR unchanged.
  function automatic pword_t gray2bin(
    input pword_t g
  );
    pword_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer bus.
// Clears to zero on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-domain controller: pointers, full, level, almost-full.
// Define FIFO_WR_SYNC2_EN to synchronise rptr_sync internally.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  w_rst_n,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  input  logic                  ovf_clr,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  typedef logic [ADDR_WIDTH:0] lvl_t;

  lvl_t wbin;
  lvl_t wbin_next;
  lvl_t wgray_next;
  lvl_t rs;
  lvl_t rbin;
  lvl_t lvl_next;
  lvl_t full_ptr;
  logic acc;
  logic full_next;
  logic afull_next;
  logic ovf_next;

`ifdef FIFO_WR_SYNC2_EN
  sync_2ff #(
    .WIDTH (ADDR_WIDTH+1)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (w_rst_n),
    .d     (rptr_sync),
    .q     (rs)
  );
`else
  assign rs = rptr_sync;
`endif

  always_comb begin
    acc        = w_en & ~full;
    wbin_next  = wbin + lvl_t'(acc);
    wgray_next = lvl_t'(bin2gray(pword_t'(wbin_next)));
    rbin       = lvl_t'(gray2bin(pword_t'(rs)));
    lvl_next   = wbin_next - rbin;
    // Write pointer one lap ahead of read: top two Gray bits inverted.
    full_ptr   = {~rs[ADDR_WIDTH:ADDR_WIDTH-1],
                  rs[ADDR_WIDTH-2:0]};
    full_next  = (wgray_next == full_ptr);
    afull_next = (lvl_next >= afull_thresh);
    ovf_next   = (w_en & full) | (overflow & ~ovf_clr);
  end

  assign mem_wen = acc;
  assign waddr   = wbin[ADDR_WIDTH-1:0];

  always_ff @(posedge wclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      full        <= full_next;
      almost_full <= afull_next;
      wlevel      <= lvl_next;
      overflow    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: vector table, directed corners, random vs occupancy model.
// Model tracks total writes/reads as integers; level = writes - visible reads.
module tb_fifo_wr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef FIFO_WR_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          wclk;
  logic          w_rst_n;
  logic          w_en;
  logic [AW:0]   rptr_sync;
  logic [AW:0]   afull_thresh;
  logic          ovf_clr;
  logic          mem_wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wlevel;
  logic          overflow;

  fifo_wr_ctrl #(
    .ADDR_WIDTH (AW)
  ) dut (
    .wclk         (wclk),
    .w_rst_n      (w_rst_n),
    .w_en         (w_en),
    .rptr_sync    (rptr_sync),
    .afull_thresh (afull_thresh),
    .ovf_clr      (ovf_clr),
    .mem_wen      (mem_wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .full         (full),
    .almost_full  (almost_full),
    .wlevel       (wlevel),
    .overflow     (overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_bad = 0;

  int wr_tot;
  int rd_drv;
  int rd_hist[LAT];
  int m_level;
  bit m_full;
  bit m_afull;
  bit m_ovf;

  typedef struct {
    bit we;
    int rd;
    int th;
    bit clr;
    bit e_wen;
    int e_waddr;
    bit e_full;
    int e_level;
    bit e_afull;
    bit e_ovf;
    int e_wptr;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [AW:0] gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_tot  = 0;
    rd_drv  = 0;
    m_level = 0;
    m_full  = 0;
    m_afull = 0;
    m_ovf   = 0;
    for (int i = 0; i < LAT; i++) rd_hist[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    w_rst_n      = 1'b0;
    w_en         = 1'b0;
    rptr_sync    = '0;
    afull_thresh = '0;
    ovf_clr      = 1'b0;
    @(negedge wclk);
    @(negedge wclk);
    w_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit we, input int rd,
                      input int th, input bit clr);
    @(negedge wclk);
    w_en         = we;
    rptr_sync    = gray(rd);
    afull_thresh = th[AW:0];
    ovf_clr      = clr;
    rd_drv       = rd;
    #1;
    chk("mem_wen", 32'(mem_wen), 32'(we && !m_full));
    chk("waddr", 32'(waddr), 32'(wr_tot % DEPTH));
    for (int i = LAT-1; i > 0; i--) rd_hist[i] = rd_hist[i-1];
    rd_hist[0] = rd;
    m_ovf = (we && m_full) || (m_ovf && !clr);
    if (we && !m_full) wr_tot++;
    m_level = wr_tot - rd_hist[LAT-1];
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= th);
    @(posedge wclk);
    #1;
    chk("wlevel", 32'(wlevel), m_level);
    chk("full", 32'(full), 32'(m_full));
    chk("almost_full", 32'(almost_full), 32'(m_afull));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("wptr", 32'(wptr), 32'(gray(wr_tot)));
  endtask

  initial begin
    w_rst_n      = 1'b1;
    w_en         = 1'b0;
    rptr_sync    = '0;
    afull_thresh = '0;
    ovf_clr      = 1'b0;
    #1;
    w_rst_n = 1'b0;
    #1;
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_wptr", 32'(wptr), 0);
    chk("rst_ovf", 32'(overflow), 0);
    do_reset();

    // Reset in the middle of a write burst, no clock edge.
    for (int i = 0; i < 5; i++) step(1, 0, 3, 0);
    @(negedge wclk);
    #2;
    w_rst_n = 1'b0;
    #1;
    chk("mid_wlevel", 32'(wlevel), 0);
    chk("mid_wptr", 32'(wptr), 0);
    chk("mid_full", 32'(full), 0);
    chk("mid_afull", 32'(almost_full), 0);
    chk("mid_ovf", 32'(overflow), 0);
    chk("mid_waddr", 32'(waddr), 0);
    do_reset();

`ifndef FIFO_WR_SYNC2_EN
    for (int i = 1; i <= 16; i++) begin
      tbl[i-1] = '{1, 0, 12, 0, 1, (i-1) % 16,
                   (i == 16), i, (i >= 12), 0,
                   i ^ (i >> 1)};
    end
    tbl[16] = '{1, 0, 17, 0, 0, 0, 1, 16, 0, 1, 24};
    tbl[17] = '{1, 0, 17, 1, 0, 0, 1, 16, 0, 1, 24};
    tbl[18] = '{0, 0, 17, 1, 0, 0, 1, 16, 0, 0, 24};
    tbl[19] = '{0, 8, 12, 0, 0, 0, 0, 8, 0, 0, 24};

    for (int k = 0; k < 20; k++) begin
      @(negedge wclk);
      w_en         = tbl[k].we;
      rptr_sync    = gray(tbl[k].rd);
      afull_thresh = tbl[k].th[AW:0];
      ovf_clr      = tbl[k].clr;
      #1;
      chk("tbl_mem_wen", 32'(mem_wen), 32'(tbl[k].e_wen));
      chk("tbl_waddr", 32'(waddr), tbl[k].e_waddr);
      @(posedge wclk);
      #1;
      chk("tbl_full", 32'(full), 32'(tbl[k].e_full));
      chk("tbl_wlevel", 32'(wlevel), tbl[k].e_level);
      chk("tbl_afull", 32'(almost_full), 32'(tbl[k].e_afull));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[k].e_ovf));
      chk("tbl_wptr", 32'(wptr), tbl[k].e_wptr);
    end

    // Continue from 16 written / 8 read and cross the pointer wrap.
    wr_tot  = 16;
    m_level = 8;
    m_full  = 0;
    m_afull = 0;
    m_ovf   = 0;
    rd_hist[0] = 8;
    for (int k = 0; k < 20; k++) begin
      step(1, wr_tot - 8, 12, 0);
      if (wr_tot == 31) chk("wrap_31", 32'(wptr), 32'h10);
      if (wr_tot == 32) chk("wrap_0", 32'(wptr), 32'h00);
    end
`else
    // Synchronised read pointer: release seen on the third edge.
    for (int i = 0; i < 16; i++) step(1, 0, 12, 0);
    chk("sync_full", 32'(full), 1);
    step(0, 4, 12, 0);
    chk("sync_hold1", 32'(full), 1);
    step(0, 4, 12, 0);
    chk("sync_hold2", 32'(full), 1);
    step(0, 4, 12, 0);
    chk("sync_fall", 32'(full), 0);
    chk("sync_level", 32'(wlevel), 12);
`endif

    do_reset();
    for (int k = 0; k < 600; k++) begin
      int rd;
      bit we;
      rd = rd_drv;
      if ($urandom_range(0, 3) == 0)
        rd = rd_drv + int'($urandom_range(0, wr_tot - rd_drv));
      we = ($urandom_range(0, 3) != 0);
      step(we, rd, int'($urandom_range(0, 17)),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
